// File: rtl/stream_mux_k_arb.sv
// K-channel valid/ready stream multiplexer with a single registered output stage.
// Arbitration is fixed at elaboration: round-robin, fixed priority or external select.
module stream_mux_k_arb #(
  parameter int K    = 4,
  parameter int SIZE = 16,
  parameter int BIT  = $clog2(K),
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [K-1:0]      in_valid,
  input  logic [K*SIZE-1:0] in_bus,
  output logic [K-1:0]      in_ready,
  input  logic [BIT-1:0]    sel_ext,
  output logic              out_valid,
  output logic [SIZE-1:0]   out_data,
  output logic [BIT-1:0]    out_chan,
  input  logic              out_ready
);

  logic [BIT-1:0] last;
  logic [K-1:0]   grant;
  logic [BIT-1:0] grant_idx;
  logic           found;
  logic           load_en;
  logic           xfer;
  int             idx;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (MODE == 0) begin
      // Search starts one past the last transferred channel and wraps.
      for (int off = 1; off <= K; off++) begin
        idx = (int'(last) + off) % K;
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = BIT'(idx);
        end
      end
    end else if (MODE == 1) begin
      for (int c = 0; c < K; c++) begin
        if (!found && in_valid[c]) begin
          found     = 1'b1;
          grant[c]  = 1'b1;
          grant_idx = BIT'(c);
        end
      end
    end else begin
      // Out-of-range selects (non power-of-two K) never grant.
      if (int'(sel_ext) < K) begin
        if (in_valid[sel_ext]) begin
          grant[sel_ext] = 1'b1;
          grant_idx      = sel_ext;
        end
      end
    end
  end

  assign in_ready = rst ? '0 : (grant & {K{load_en}});
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= BIT'(K - 1);
    end else if (xfer) begin
      out_data  <= in_bus[int'(grant_idx)*SIZE +: SIZE];
      out_chan  <= grant_idx;
      out_valid <= 1'b1;
      if (MODE == 0) last <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_k_arb.md
Name: stream_mux_k_arb

Overview:
- Parametrised successor to the combinational K-to-1 mux: K-channel streaming multiplexer with valid/ready handshakes on every input and on the output.
- Internal arbiter with selectable mode: round-robin, fixed priority or externally steered.
- One registered output stage giving 1-cycle latency and full throughput (one beat per cycle).
- Sits between multiple producer blocks and a single shared consumer (datapath or memory port).

Parameters:
- K, 4, number of input channels (K >= 2).
- SIZE, 16, data width per channel in bits.
- BIT, $clog2(K), width of channel index signals.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = external select.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  K  bit i high means channel i presents a beat.
- in_bus  input  K*SIZE  flattened input data; channel i = in_bus[i*SIZE +: SIZE].
- in_ready  output  K  bit i high means channel i's beat is accepted this cycle.
- sel_ext  input  BIT  channel select, used only when MODE = 2; ignored otherwise.
- out_valid  output  1  output register holds a valid beat.
- out_data  output  SIZE  registered output data.
- out_chan  output  BIT  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
Clock, reset and transfer rules:
- Single clock domain.
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, round-robin pointer last = K-1, so channel 0 has highest round-robin priority after reset.
- load_en = !out_valid || out_ready. The output register can take a new beat when it is empty or is being drained this cycle.
- grant is one-hot over K, computed combinationally from in_valid and the current state.
- grant is all-zero when no eligible channel is valid.
- in_ready = grant & {K{load_en}}. At most one in_ready bit is high per cycle. in_ready never depends on out_ready when out_valid = 0.
- Input transfer on channel i happens when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data;
  - out_chan <= i;
  - out_valid <= 1.
- If out_ready && out_valid and no input transfer occurs, out_valid <= 0 on the next edge. out_data and out_chan hold their values.
- Stall (out_valid && !out_ready): out_data and out_chan stay stable, and all in_ready bits are 0.
- Latency: an accepted beat appears on the output 1 cycle later. Back-to-back transfers sustain 1 beat per cycle while out_ready = 1.

Arbitration by mode:
- MODE 0 (round-robin):
  - Search the valid channels in order last+1, last+2, ... mod K; the first valid channel is granted.
  - last <= granted index only on an actual input transfer. A grant offered during a stall does not advance the pointer.
  - Wrap-around: after channel K-1 is granted, channel 0 has highest priority.
- MODE 1 (fixed priority): the lowest-index valid channel is granted. The last pointer is unused and stays at its reset value.
- MODE 2 (external select):
  - Channel sel_ext is granted iff in_valid[sel_ext]; otherwise there is no grant.
  - If sel_ext >= K (possible when K is not a power of 2), there is no grant.
- Mode is a parameter only; there is no run-time switching.

Boundary conditions:
- All in_valid = 0: no grant and no input transfer; the output drains normally.
- Simultaneous drain and load in the same cycle: out_valid stays 1 and the new beat replaces the old on that edge. No bubble and no duplicate.
- The protocol requires in_valid to stay high until accepted. The block does not store unaccepted beats.
- Reset asserted mid-operation: any held output beat is discarded, and outputs and pointer return to reset values on that edge regardless of other inputs.
- in_ready is 0 for every channel while rst = 1.

Test Plan:
1. MODE 0, K=4, SIZE=16, in_bus = {AAAA,BBBB,CCCC,DDDD}, all in_valid = 1111, out_ready = 1 from reset release -> out_data sequence DDDD, CCCC, BBBB, AAAA, DDDD... and out_chan 0,1,2,3,0, one beat per cycle starting 1 cycle after the first grant.
2. MODE 0, out_ready held 0 for 3 cycles after the first beat -> out_data = DDDD stable, in_ready = 0000, pointer unchanged. When out_ready returns to 1, the next beat is channel 1 (CCCC).
3. MODE 1, in_valid = 1010 -> every beat is from channel 1 (CCCC). When in_valid becomes 1000, beats come from channel 3 (AAAA).
4. MODE 2, sel_ext = 2, in_valid = 0100 -> out_data = BBBB, out_chan = 2. With sel_ext = 2 and in_valid = 0001 -> no grant, out_valid drops after the drain.
5. MODE 0, in_valid = 0000 for 2 cycles after a beat is held and out_ready = 1 -> out_valid goes 1 then 0, out_data holds its last value.
6. Assert rst while out_valid = 1 and out_ready = 0 -> next edge gives out_valid = 0, out_data = 0000, out_chan = 0. The first grant after reset is channel 0 when all channels are valid.
